trng_harvester: RTL and testbench
=================================

# trng_harvester

Consumer side of the ring-oscillator entropy source: samples the free-running raw random bit and removes bias with a von Neumann corrector. It packs corrected bits into WIDTH-bit words and presents them on a valid/ready interface to downstream logic. It sits between the asynchronous oscillator output and any synchronous random-number user.

## Interface
- WIDTH, 16: output word width; legal range 2 to 64.
- SYNC_STAGES, 2: synchronizer flop count on raw_bit; minimum 2.
- SAMPLE_DIV, 4: one sample is taken every SAMPLE_DIV clocks; minimum 1.
- RCT_CUTOFF, 32: repetition-count health-test cutoff, counted in consecutive identical samples.
- clk  in  1  single system clock.
- rst  in  1  reset, synchronous, active-high.
- raw_bit  in  1  oscillator output; asynchronous to clk.
- en  in  1  harvesting enable.
- rnd_data  out  WIDTH  corrected random word.
- rnd_valid  out  1  rnd_data holds an unconsumed word.
- rnd_ready  in  1  consumer accepts the word.
- health_fail  out  1  sticky repetition-count failure flag.

## Operation
- Reset values: rnd_data=0, rnd_valid=0, health_fail=0. Synchronizer flops=0, divider=0, pair state=IDLE, bit count=0, shift register=0, repetition counter=0.
- The synchronizer chain always runs. The divider counts 0..SAMPLE_DIV-1 while en=1. The sample strobe fires on the cycle the divider equals SAMPLE_DIV-1.
- Pair FSM, advanced on each strobe:
  - IDLE: store the sample, move to HAVE_FIRST.
  - HAVE_FIRST: compare with the stored sample and return to IDLE. Pair (1,0) emits 1; pair (0,1) emits 0; equal pairs emit nothing.
- Packing: an emitted bit shifts in at the LSB, `shreg <= {shreg[WIDTH-2:0], bit}`, so the first bit ends up at the MSB. When the WIDTH-th bit arrives:
  - If the output register is empty, or is handed off in the same cycle, load it, set rnd_valid=1 and clear the bit count.
  - Otherwise the shift register is full. It stalls, and further emitted bits are dropped until the output register frees.
- Handshake: a transfer occurs when rnd_valid & rnd_ready. rnd_data is stable while rnd_valid=1 and rnd_ready=0. A transfer with no new word ready clears rnd_valid on the next edge. A transfer coinciding with a completed word reloads, and rnd_valid stays 1.
- en=0: divider and pair FSM return to 0/IDLE. The partial word and the output register are retained, and the handshake keeps working.
- Repetition counter: counts consecutive identical raw samples, before correction. Reaching RCT_CUTOFF sets health_fail. While health_fail=1:
  - the shift register and bit count are cleared and stay cleared;
  - rnd_valid is forced to 0 and no new word loads.
  - Only rst clears health_fail.

## Timing
- raw_bit to sample: SYNC_STAGES clocks, plus alignment to the next strobe.
- Word completion to rnd_valid=1: 1 clock, registered.
- Transfer to rnd_valid=0: 1 clock.
- health_fail rises 1 clock after the strobe that makes the repetition count reach RCT_CUTOFF. rnd_valid falls on that same edge.
- rst mid-word takes effect on the next edge: the partial word and any held word are discarded.

## Configuration
- TRNG_HEALTH_EN defined: the repetition-count test and health_fail behave as above.
- TRNG_HEALTH_EN undefined: no counter is built, health_fail is tied to 0, and harvesting never halts.

## Structure
- Shared package trng_pkg holds:
  - the pair-state enum {IDLE, HAVE_FIRST};
  - default constants TRNG_WIDTH=16 and TRNG_RCT_CUTOFF=32.
- One sub-module, trng_vn_corrector: takes the sample and strobe, and outputs bit and bit_valid. The synchronizer, divider, packer, handshake and health test stay in trng_harvester.

## Test plan
All scenarios use SAMPLE_DIV=1, WIDTH=16, RCT_CUTOFF=32, and a bench that drives raw_bit synchronously.
- Samples 1,0 repeated 16 pairs, rnd_ready=1 -> one word 0xFFFF, rnd_valid high for exactly 1 cycle.
- Samples 0,1 repeated 16 pairs -> 0x0000. Samples 1,1,0,0 repeated 32 pairs -> rnd_valid never rises.
- Pairs alternating (1,0),(0,1) for 16 pairs -> 0xAAAA.
- Backpressure, rnd_ready=0 while 48 pairs of (1,0) are supplied:
  - first word held stable and second word stalled in the shift register;
  - raise rnd_ready for 1 cycle -> rnd_valid stays 1 with the second word;
  - no third word appears.
- TRNG_HEALTH_EN defined, raw_bit held at 1 for 40 samples -> health_fail=1 after the 32nd sample, rnd_valid=0. Later good data yields no word until rst.
- rst asserted after 10 pairs of (1,0) -> all outputs 0. Then 16 fresh (0,1) pairs -> 0x0000, with no stale 1s.

Source files
------------

// File: rtl/trng_pkg.sv
// trng_pkg: shared pair-state type and default sizing for the TRNG harvester
package trng_pkg;
  typedef enum logic {IDLE, HAVE_FIRST} pair_state_t;
  localparam int TRNG_WIDTH = 16;
  localparam int TRNG_RCT_CUTOFF = 32;
endpackage

// File: rtl/trng_vn_corrector.sv
// trng_vn_corrector: von Neumann debiasing over consecutive strobed samples
module trng_vn_corrector
  import trng_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic sample,
  input  logic strobe,
  output logic vn_bit,
  output logic vn_valid
);
  pair_state_t state, state_d;
  logic first;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      first <= 1'b0;
    end else begin
      state <= state_d;
      if (strobe && state == IDLE) first <= sample;
    end
  end
  always_comb begin
    state_d = !en ? IDLE : strobe ? (state == IDLE ? HAVE_FIRST : IDLE) : state;
    vn_bit = first;
    vn_valid = strobe && state == HAVE_FIRST && sample != first;
  end
endmodule

// File: rtl/trng_harvester.sv
// trng_harvester: samples raw_bit, debiases, packs WIDTH-bit words onto valid/ready.
// Define TRNG_HEALTH_EN to build the repetition-count health test.
module trng_harvester
  import trng_pkg::*;
#(
  parameter int WIDTH = TRNG_WIDTH,
  parameter int SYNC_STAGES = 2,
  parameter int SAMPLE_DIV = 4,
  parameter int RCT_CUTOFF = TRNG_RCT_CUTOFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             raw_bit,
  input  logic             en,
  output logic [WIDTH-1:0] rnd_data,
  output logic             rnd_valid,
  input  logic             rnd_ready,
  output logic             health_fail
);
  localparam int DW = SAMPLE_DIV > 1 ? $clog2(SAMPLE_DIV) : 1;
  localparam int CW = $clog2(WIDTH + 1);
  if (WIDTH < 2 || WIDTH > 64 || SYNC_STAGES < 2 || SAMPLE_DIV < 1 || RCT_CUTOFF < 1) begin : g_bad_param
    $error("trng_harvester: illegal parameter value");
  end
  logic [SYNC_STAGES-1:0] sync;
  logic [DW-1:0] div;
  logic [WIDTH-1:0] shreg, shreg_d;
  logic [CW-1:0] cnt;
  logic sample, strobe, vn_bit, vn_valid, xfer, full, out_free, word_done, load, hf_kill;
  assign sample = sync[SYNC_STAGES-1];
  assign strobe = en && div == DW'(SAMPLE_DIV - 1);
  assign xfer = rnd_valid && rnd_ready;
  assign full = cnt == CW'(WIDTH);
  assign out_free = !rnd_valid || xfer;
  assign shreg_d = {shreg[WIDTH-2:0], vn_bit};
  assign word_done = vn_valid && !full && cnt == CW'(WIDTH - 1);
  assign load = !hf_kill && out_free && (full || word_done);
  always_ff @(posedge clk) begin
    sync <= rst ? '0 : {sync[SYNC_STAGES-2:0], raw_bit};
    div <= (rst || !en || strobe) ? '0 : div + 1'b1;
  end
  trng_vn_corrector u_vn (
    .clk(clk), .rst(rst), .en(en), .sample(sample), .strobe(strobe),
    .vn_bit(vn_bit), .vn_valid(vn_valid)
  );
  // A full shift register holds its word until the output frees; bits arriving meanwhile are lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg <= '0;
      cnt <= '0;
      rnd_data <= '0;
      rnd_valid <= 1'b0;
    end else if (hf_kill) begin
      shreg <= '0;
      cnt <= '0;
      rnd_valid <= 1'b0;
    end else begin
      if (load) begin
        rnd_data <= full ? shreg : shreg_d;
        cnt <= '0;
      end else if (word_done) begin
        shreg <= shreg_d;
        cnt <= CW'(WIDTH);
      end else if (vn_valid && !full) begin
        shreg <= shreg_d;
        cnt <= cnt + 1'b1;
      end
      rnd_valid <= load || (rnd_valid && !xfer);
    end
  end
`ifdef TRNG_HEALTH_EN
  localparam int RW = $clog2(RCT_CUTOFF + 1);
  logic [RW-1:0] rct, rct_d;
  logic last, hf_set;
  assign rct_d = (rct != '0 && sample == last) ? (rct == RW'(RCT_CUTOFF) ? rct : rct + 1'b1) : RW'(1);
  assign hf_set = strobe && rct_d == RW'(RCT_CUTOFF);
  assign hf_kill = health_fail || hf_set;
  always_ff @(posedge clk) begin
    if (rst) begin
      rct <= '0;
      last <= 1'b0;
      health_fail <= 1'b0;
    end else begin
      if (strobe) begin
        rct <= rct_d;
        last <= sample;
      end
      if (hf_set) health_fail <= 1'b1;
    end
  end
`else
  assign health_fail = 1'b0;
  assign hf_kill = 1'b0;
`endif
endmodule

// File: tb/tb_trng_harvester.sv
// tb_trng_harvester: directed and random streams checked against a pair/bit-level model
module tb_trng_harvester;
  localparam int W = 16;
  localparam int CUT = 32;
  logic clk = 0, rst = 1, raw_bit = 0, en = 0, rnd_ready = 0;
  logic [W-1:0] rnd_data;
  logic rnd_valid, health_fail;
  int ncmp = 0, nfail = 0;
  logic d1 = 0, d2 = 0, first = 0, have = 0, last = 0, mhf = 0;
  int run = 0, nb = 0, vcnt = 0;
  logic [W-1:0] acc = '0, lastw = '0, pd = '0;
  logic pv = 0, pr = 0;
  logic [W-1:0] expq[$];
  logic sq[$];

  always #5 clk = ~clk;

  trng_harvester #(.WIDTH(W), .SYNC_STAGES(2), .SAMPLE_DIV(1), .RCT_CUTOFF(CUT)) dut (
    .clk(clk), .rst(rst), .raw_bit(raw_bit), .en(en), .rnd_data(rnd_data),
    .rnd_valid(rnd_valid), .rnd_ready(rnd_ready), .health_fail(health_fail)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic mreset();
    d1 = 0; d2 = 0; have = 0; run = 0; last = 0; mhf = 0; acc = '0; nb = 0; pv = 0;
    expq.delete();
  endtask

  // Reference: run-length health test, then pairwise debias, then MSB-first word packing.
  task automatic msample(input logic v);
    run = (run > 0 && v == last) ? run + 1 : 1;
    last = v;
`ifdef TRNG_HEALTH_EN
    if (run >= CUT) mhf = 1;
`endif
    if (mhf) begin acc = '0; nb = 0; end
    if (!have) begin
      first = v; have = 1;
    end else begin
      have = 0;
      if (first != v && !mhf) begin
        acc = {acc[W-2:0], first};
        nb++;
        if (nb == W) begin expq.push_back(acc); nb = 0; end
      end
    end
  endtask

  task automatic do_reset();
    rst = 1; raw_bit = 0; en = 0; rnd_ready = 0;
    @(posedge clk); #1;
    rst = 0;
    mreset();
  endtask

  task automatic tick(input logic r, input logic e, input int rdy);
    logic re, smp;
    re = (rdy == 2) ? logic'($urandom_range(0, 3) != 0) : rdy[0];
    raw_bit = r; en = e; rnd_ready = re;
    if (rnd_valid && re) begin
      chk("word_expected", expq.size() > 0, 1);
      if (expq.size() > 0) chk("word", rnd_data, expq.pop_front());
      lastw = rnd_data;
    end
    pv = rnd_valid; pd = rnd_data; pr = re;
    @(posedge clk); #1;
    smp = d2; d2 = d1; d1 = r;
    if (!e) have = 0; else msample(smp);
    if (pv && !pr && !mhf) begin
      chk("hold_valid", rnd_valid, 1);
      chk("hold_data", rnd_data, pd);
    end
    chk("health", health_fail, mhf);
    if (rnd_valid) vcnt++;
  endtask

  task automatic stream(input int rdy);
    foreach (sq[i]) tick(sq[i], 1, rdy);
    tick(0, 1, rdy); tick(0, 1, rdy); tick(0, 0, rdy);
    sq.delete();
  endtask

  task automatic pairs(input int n, input logic a, input logic b);
    repeat (n) begin sq.push_back(a); sq.push_back(b); end
  endtask

  task automatic idle(input int n, input int rdy);
    repeat (n) tick(0, 0, rdy);
  endtask

  initial begin
    do_reset();
    chk("rst_valid", rnd_valid, 0);
    chk("rst_data", rnd_data, 0);
    chk("rst_health", health_fail, 0);

    vcnt = 0; lastw = 16'h5a5a; pairs(16, 1, 0); stream(1); idle(3, 1);
    chk("ones_word", lastw, 16'hFFFF);
    chk("ones_vcycles", vcnt, 1);

    vcnt = 0; lastw = 16'h5a5a; pairs(16, 0, 1); stream(1); idle(3, 1);
    chk("zeros_word", lastw, 16'h0000);
    chk("zeros_vcycles", vcnt, 1);

    vcnt = 0; repeat (16) begin sq.push_back(1); sq.push_back(1); sq.push_back(0); sq.push_back(0); end
    stream(1); idle(3, 1);
    chk("equal_pairs_vcycles", vcnt, 0);

    vcnt = 0; lastw = 16'h5a5a;
    repeat (8) begin pairs(1, 1, 0); pairs(1, 0, 1); end
    stream(1); idle(3, 1);
    chk("alt_word", lastw, 16'hAAAA);
    chk("alt_vcycles", vcnt, 1);

    do_reset();
    pairs(16, 1, 0); pairs(16, 0, 1); pairs(16, 1, 0); stream(0); idle(5, 0);
    chk("bp_valid", rnd_valid, 1);
    chk("bp_data", rnd_data, 16'hFFFF);
    tick(0, 0, 1);
    chk("bp_reload_valid", rnd_valid, 1);
    chk("bp_reload_data", rnd_data, 16'h0000);
    tick(0, 0, 0); tick(0, 0, 1);
    chk("bp_empty", rnd_valid, 0);
    expq.delete();
    idle(5, 1);
    chk("bp_no_third", rnd_valid, 0);

`ifdef TRNG_HEALTH_EN
    do_reset();
    pairs(16, 1, 0); stream(0);
    chk("hf_pre_valid", rnd_valid, 1);
    repeat (40) sq.push_back(1);
    stream(0);
    chk("hf_set", health_fail, 1);
    chk("hf_valid_drop", rnd_valid, 0);
    expq.delete();
    pairs(16, 1, 0); stream(1); idle(3, 1);
    chk("hf_no_word", rnd_valid, 0);
    do_reset();
    chk("hf_cleared", health_fail, 0);
`endif

    do_reset();
    pairs(16, 1, 0); pairs(10, 1, 0); stream(0);
    chk("mid_valid", rnd_valid, 1);
    do_reset();
    chk("mid_rst_valid", rnd_valid, 0);
    chk("mid_rst_data", rnd_data, 0);
    chk("mid_rst_health", health_fail, 0);
    lastw = 16'h5a5a; pairs(16, 0, 1); stream(1); idle(3, 1);
    chk("mid_fresh_word", lastw, 16'h0000);

    do_reset();
    for (int k = 0; k < 4; k++) begin
      repeat ($urandom_range(20, 80) * 2) sq.push_back(logic'($urandom_range(0, 1)));
      stream(2); idle(3, 1);
    end
    idle(4, 1);
    chk("rand_all_delivered", expq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
